// File: rtl/cla_pipe_adder_if.sv
// Streaming operand/result bundle for cla_pipe_adder.
// The sub signal exists only when CLA_SUB_EN is defined.
interface cla_pipe_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef CLA_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin,
`ifdef CLA_SUB_EN
      output sub,
`endif
      output out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin,
`ifdef CLA_SUB_EN
      input  sub,
`endif
      input  out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one CHUNK-bit slice resolved per stage, carry
// registered between stages. Define CLA_SUB_EN to add the subtract (a - b - !cin) path.
module cla_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic             clk,
   input logic             rst_n,
   cla_pipe_adder_if.slave bus
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
         $error("cla_pipe_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
      end
   endgenerate

   logic             adv;
   logic [WIDTH-1:0] b_eff;

   // Per-stage registers: the beat's operands, partial sum and carry out of the slice.
   logic [STAGES-1:0] vld_reg;
   logic [STAGES-1:0] c_reg;
   logic [WIDTH-1:0]  a_reg   [STAGES];
   logic [WIDTH-1:0]  b_reg   [STAGES];
   logic [WIDTH-1:0]  sum_reg [STAGES];

   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] c_in;
   logic [STAGES-1:0] c_next;
   logic [WIDTH-1:0]  a_in     [STAGES];
   logic [WIDTH-1:0]  b_in     [STAGES];
   logic [WIDTH-1:0]  s_in     [STAGES];
   logic [WIDTH-1:0]  sum_next [STAGES];

`ifdef CLA_SUB_EN
   assign b_eff = bus.sub ? ~bus.b : bus.b;
`else
   assign b_eff = bus.b;
`endif

   // One global stall: the whole pipe moves only when the output slot is free or draining.
   assign adv          = ~vld_reg[LAST] | bus.out_ready;
   assign bus.in_ready = adv;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [CHUNK-1:0] g;
         logic [CHUNK-1:0] p;
         logic [CHUNK:0]   cc;
         logic [WIDTH-1:0] s_loc;

         if (gi == 0) begin : g_head
            assign v_in[gi] = bus.in_valid;
            assign a_in[gi] = bus.a;
            assign b_in[gi] = b_eff;
            assign s_in[gi] = '0;
            assign c_in[gi] = bus.cin;
         end else begin : g_body
            assign v_in[gi] = vld_reg[gi-1];
            assign a_in[gi] = a_reg[gi-1];
            assign b_in[gi] = b_reg[gi-1];
            assign s_in[gi] = sum_reg[gi-1];
            assign c_in[gi] = c_reg[gi-1];
         end

         assign g = a_in[gi][gi*CHUNK +: CHUNK] & b_in[gi][gi*CHUNK +: CHUNK];
         assign p = a_in[gi][gi*CHUNK +: CHUNK] ^ b_in[gi][gi*CHUNK +: CHUNK];

         always_comb begin
            cc    = '0;
            cc[0] = c_in[gi];
            for (int i = 0; i < CHUNK; i++) begin
               cc[i+1] = g[i] | (p[i] & cc[i]);
            end
         end

         // Lower chunks already resolved upstream pass through untouched.
         always_comb begin
            s_loc                      = s_in[gi];
            s_loc[gi*CHUNK +: CHUNK]   = p ^ cc[CHUNK-1:0];
         end

         assign sum_next[gi] = s_loc;
         assign c_next[gi]   = cc[CHUNK];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_reg <= '0;
         c_reg   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]   <= '0;
            b_reg[k]   <= '0;
            sum_reg[k] <= '0;
         end
      end else if (adv) begin
         vld_reg <= v_in;
         for (int k = 0; k < STAGES; k++) begin
            if (v_in[k]) begin
               a_reg[k]   <= a_in[k];
               b_reg[k]   <= b_in[k];
               sum_reg[k] <= sum_next[k];
               c_reg[k]   <= c_next[k];
            end
         end
      end
   end

   assign bus.out_valid = vld_reg[LAST];
   assign bus.sum       = sum_reg[LAST];
   assign bus.cout      = c_reg[LAST];
   // b_reg holds the (possibly inverted) operand, so this covers subtraction too.
   assign bus.ovf       = (a_reg[LAST][WIDTH-1] == b_reg[LAST][WIDTH-1]) &
                          (sum_reg[LAST][WIDTH-1] != a_reg[LAST][WIDTH-1]);
endmodule
